// File: rtl/pipe_ctrl.sv
// Pipeline stall control for the 5-stage MIPS core, plus the radix-2 restoring
// divider that serves DIV/DIVU from EX and delivers its result to HI/LO.
module pipe_ctrl #(
  parameter int DATA_W = 32,
  parameter int STAGES = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_r1_en,
  input  logic [4:0]        id_r1_addr,
  input  logic              id_r2_en,
  input  logic [4:0]        id_r2_addr,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_wreg_addr,
  input  logic              mem_stall_req,
  input  logic              ex_div_start,
  input  logic              ex_div_signed,
  input  logic [DATA_W-1:0] ex_div_opa,
  input  logic [DATA_W-1:0] ex_div_opb,
  input  logic              div_cancel,
  output logic [STAGES-1:0] stall,
  output logic              div_valid,
  output logic [DATA_W-1:0] div_hi,
  output logic [DATA_W-1:0] div_lo
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, BY_ZERO, ON, END} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] quo_q;      // dividend magnitude shifting out, quotient shifting in
  logic [DATA_W-1:0] rem_q;      // partial remainder
  logic [DATA_W-1:0] dvs_q;      // divisor magnitude
  logic              neg_quo_q;
  logic              neg_rem_q;

  logic              load_use;
  logic              div_stall;
  logic              op_abort;
  logic              last_step;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   rem_diff;
  logic              q_bit;
  logic [DATA_W-1:0] step_q;
  logic [DATA_W-1:0] step_r;

  assign load_use = ex_is_load && (ex_wreg_addr != 5'd0) &&
                    ((id_r1_en && (id_r1_addr == ex_wreg_addr)) ||
                     (id_r2_en && (id_r2_addr == ex_wreg_addr)));

  assign div_stall = ex_div_start && (state_q != END) && !div_cancel;
  assign div_valid = (state_q == END) && !div_cancel;

  // A divide in flight is abandoned on flush or when EX no longer holds the DIV.
  assign op_abort  = div_cancel || !ex_div_start;
  assign last_step = (cnt_q == CNT_W'(DATA_W - 1));

  // Stall vector: bus wait outranks the divider, which outranks load-use.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    stall = '0;
    if (mem_stall_req)  stall = STAGES'(6'b011111);
    else if (div_stall) stall = STAGES'(6'b001111);
    else if (load_use)  stall = STAGES'(6'b000111);
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The shifted remainder is below 2*divisor, so bit DATA_W of the difference is
  // set exactly when the subtraction would go negative.
  always_comb begin
    rem_shift = {rem_q, quo_q[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    q_bit     = !rem_diff[DATA_W];
    step_r    = q_bit ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    step_q    = {quo_q[DATA_W-2:0], q_bit};
  end

  // Divider next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ex_div_start && !div_cancel)
          state_d = (ex_div_opb == '0) ? BY_ZERO : ON;
      end
      BY_ZERO: begin
        state_d = op_abort ? IDLE : END;
      end
      ON: begin
        if (op_abort)       state_d = IDLE;
        else if (last_step) state_d = END;
      end
      END: begin
        if (div_cancel || !mem_stall_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Divider datapath: latch magnitudes on accept, iterate in ON, publish on entry to END.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div_lo    <= '0;
      div_hi    <= '0;
    end else if (state_q == IDLE && state_d == ON) begin
      // Unsigned negation of 0x80000000 yields 0x80000000, the correct magnitude.
      quo_q     <= (ex_div_signed && ex_div_opa[DATA_W-1]) ? -ex_div_opa : ex_div_opa;
      dvs_q     <= (ex_div_signed && ex_div_opb[DATA_W-1]) ? -ex_div_opb : ex_div_opb;
      neg_quo_q <= ex_div_signed && (ex_div_opa[DATA_W-1] ^ ex_div_opb[DATA_W-1]);
      neg_rem_q <= ex_div_signed && ex_div_opa[DATA_W-1];
      cnt_q     <= '0;
      rem_q     <= '0;
    end else if (state_q == ON && state_d != IDLE) begin
      quo_q <= step_q;
      rem_q <= step_r;
      cnt_q <= cnt_q + 1'b1;
      if (state_d == END) begin
        div_lo <= neg_quo_q ? -step_q : step_q;
        div_hi <= neg_rem_q ? -step_r : step_r;
      end
    end else if (state_q == BY_ZERO && state_d == END) begin
      div_lo <= '0;
      div_hi <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl: stall priority, load-use
// detection and DIV/DIVU results/latency against an arithmetic reference.
module tb_pipe_ctrl;

  localparam int DATA_W = 32;
  localparam int STAGES = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_r1_en, id_r2_en;
  logic [4:0]        id_r1_addr, id_r2_addr;
  logic              ex_is_load;
  logic [4:0]        ex_wreg_addr;
  logic              mem_stall_req;
  logic              ex_div_start, ex_div_signed;
  logic [DATA_W-1:0] ex_div_opa, ex_div_opb;
  logic              div_cancel;
  logic [STAGES-1:0] stall;
  logic              div_valid;
  logic [DATA_W-1:0] div_hi, div_lo;

  int n_checks = 0;
  int n_errors = 0;

  pipe_ctrl #(.DATA_W(DATA_W), .STAGES(STAGES)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_r1_en     (id_r1_en),
    .id_r1_addr   (id_r1_addr),
    .id_r2_en     (id_r2_en),
    .id_r2_addr   (id_r2_addr),
    .ex_is_load   (ex_is_load),
    .ex_wreg_addr (ex_wreg_addr),
    .mem_stall_req(mem_stall_req),
    .ex_div_start (ex_div_start),
    .ex_div_signed(ex_div_signed),
    .ex_div_opa   (ex_div_opa),
    .ex_div_opb   (ex_div_opb),
    .div_cancel   (div_cancel),
    .stall        (stall),
    .div_valid    (div_valid),
    .div_hi       (div_hi),
    .div_lo       (div_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference quotient/remainder from plain arithmetic (truncating division).
  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = '0;
      r = '0;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Expected stall vector from the current inputs and whether a divide still owes cycles.
  function automatic logic [5:0] exp_stall(input bit div_busy);
    bit lu;
    lu = ex_is_load && (ex_wreg_addr != 5'd0) &&
         ((id_r1_en && id_r1_addr == ex_wreg_addr) || (id_r2_en && id_r2_addr == ex_wreg_addr));
    if (mem_stall_req) return 6'b011111;
    if (div_busy)      return 6'b001111;
    if (lu)            return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Random ID/EX register traffic over a tiny address range so hazards are frequent.
  task automatic rand_side();
    id_r1_en     = 1'($urandom_range(0, 1));
    id_r2_en     = 1'($urandom_range(0, 1));
    id_r1_addr   = 5'($urandom_range(0, 3));
    id_r2_addr   = 5'($urandom_range(0, 3));
    ex_is_load   = 1'($urandom_range(0, 1));
    ex_wreg_addr = 5'($urandom_range(0, 3));
  endtask

  // One DIV/DIVU from issue to retirement. end_hold = bus-wait cycles while the
  // result is shown; abort_at >= 0 flushes (or resets) the divide at that cycle.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int end_hold, input int abort_at, input bit abort_rst);
    int          lat;
    logic [31:0] eq, er;
    lat = (b == 32'd0) ? 2 : 33;
    ref_div(sgn, a, b, eq, er);
    next_cycle();
    ex_div_start  = 1'b1;
    ex_div_signed = sgn;
    ex_div_opa    = a;
    ex_div_opb    = b;
    mem_stall_req = 1'b0;
    rand_side();
    for (int c = 0; c <= lat + end_hold; c++) begin
      if (c > 0) begin
        next_cycle();
        ex_div_opa = $urandom;
        ex_div_opb = $urandom;
        rand_side();
        if (c < lat) mem_stall_req = ($urandom_range(0, 7) == 0);
        else         mem_stall_req = (c < lat + end_hold);
        if (lat == 33 && c == 5) begin
          mem_stall_req = 1'b1;
          ex_is_load    = 1'b1;
          ex_wreg_addr  = 5'd4;
          id_r2_en      = 1'b1;
          id_r2_addr    = 5'd4;
        end
      end
      if (c == abort_at) begin
        if (abort_rst) rst = 1'b1;
        else           div_cancel = 1'b1;
      end
      @(negedge clk);
      if (c == abort_at) begin
        check("abort_valid", 32'(div_valid), 32'd0);
        if (!abort_rst) check("cancel_stall", 32'(stall), 32'(exp_stall(1'b0)));
        next_cycle();
        rst           = 1'b0;
        div_cancel    = 1'b0;
        ex_div_start  = 1'b0;
        mem_stall_req = 1'b0;
        rand_side();
        @(negedge clk);
        check("abort_idle_valid", 32'(div_valid), 32'd0);
        check("abort_idle_stall", 32'(stall), 32'(exp_stall(1'b0)));
        if (abort_rst) begin
          check("rst_lo", div_lo, 32'd0);
          check("rst_hi", div_hi, 32'd0);
        end
        return;
      end
      if (c < lat) begin
        check("busy_stall", 32'(stall), 32'(exp_stall(1'b1)));
        check("busy_valid", 32'(div_valid), 32'd0);
      end else begin
        check("done_valid", 32'(div_valid), 32'd1);
        check("done_lo", div_lo, eq);
        check("done_hi", div_hi, er);
        check("done_stall", 32'(stall), 32'(exp_stall(1'b0)));
      end
    end
    next_cycle();
    ex_div_start  = 1'b0;
    mem_stall_req = 1'b0;
    rand_side();
    @(negedge clk);
    check("retire_valid", 32'(div_valid), 32'd0);
    check("hold_lo", div_lo, eq);
    check("hold_hi", div_hi, er);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs;
    rst           = 1'b1;
    id_r1_en      = 1'b0;
    id_r2_en      = 1'b0;
    id_r1_addr    = '0;
    id_r2_addr    = '0;
    ex_is_load    = 1'b0;
    ex_wreg_addr  = '0;
    mem_stall_req = 1'b0;
    ex_div_start  = 1'b0;
    ex_div_signed = 1'b0;
    ex_div_opa    = '0;
    ex_div_opb    = '0;
    div_cancel    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_valid", 32'(div_valid), 32'd0);
    check("reset_lo", div_lo, 32'd0);
    check("reset_hi", div_hi, 32'd0);
    next_cycle();
    rst = 1'b0;

    // Load to r4 in EX, ID reads r4 as source 2: one-cycle bubble.
    next_cycle();
    ex_is_load = 1'b1; ex_wreg_addr = 5'd4; id_r2_en = 1'b1; id_r2_addr = 5'd4;
    @(negedge clk);
    check("load_use_stall", 32'(stall), 32'h07);
    next_cycle();
    ex_is_load = 1'b0;
    @(negedge clk);
    check("load_use_released", 32'(stall), 32'h00);
    next_cycle();
    ex_is_load = 1'b1; ex_wreg_addr = 5'd0; id_r2_addr = 5'd0;
    @(negedge clk);
    check("load_r0_no_stall", 32'(stall), 32'h00);

    // Random hazard/bus-wait traffic with no divide.
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      rand_side();
      mem_stall_req = 1'($urandom_range(0, 3) == 0);
      @(negedge clk);
      check("rand_stall", 32'(stall), 32'(exp_stall(1'b0)));
    end
    next_cycle();
    mem_stall_req = 1'b0;

    // Directed divides.
    do_div(1'b0, 32'd100, 32'd7, 0, -1, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, -1, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, 1'b0);
    do_div(1'b0, 32'd5, 32'd0, 0, -1, 1'b0);
    do_div(1'b0, 32'd1000, 32'd9, 3, -1, 1'b0);
    do_div(1'b0, 32'd12345, 32'd17, 0, 10, 1'b0);
    do_div(1'b0, 32'd9, 32'd3, 0, -1, 1'b0);
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 20, 1'b1);
    do_div(1'b1, 32'd7, 32'd0, 0, 1, 1'b0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1, -1, 1'b0);

    // Random divides, biased toward the awkward operands.
    for (int i = 0; i < 14; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      do_div(rs, ra, rb, int'($urandom_range(0, 2)), -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
